// File: rtl/cpu_pipe_pkg.sv
// Shared types and widths for the CPU pipeline boundary registers.
package cpu_pipe_pkg;

  // Occupancy of a stage register (TWO only reachable with the skid slot).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned EXMEM_CTRL_W = 6;
  localparam int unsigned EXMEM_DATA_W = 107;

  // Bit positions of the fields inside the EX/MEM control bundle.
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_BRANCH     = 3;
  localparam int unsigned CTRL_M2R_LSB    = 4;
  localparam int unsigned CTRL_M2R_MSB    = 5;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, stall, flush and
// an optional skid slot that keeps in_ready off the downstream ready path.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_t       state_q, state_d;
  logic              main_v, skid_v;
  logic              push, pop;
  logic              load_main, load_skid, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == TWO);
  assign push   = in_valid & in_ready;
  assign pop    = main_v & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state and slot load strobes; flush wins over push and pop
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end else if (push) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main slot: loads from upstream or promotes the skid entry
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (main_from_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk) begin
        if (reset) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (load_skid) begin
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
      assign in_ready = ~skid_v;
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = ~main_v | out_ready;
    end
  endgenerate

  // Bubbles carry an all-zero control bundle so no side effects leak downstream
  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg, with and without skid slot.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 6;
  localparam int unsigned DW = 107;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush [2];
  logic          iv    [2];
  logic          ir    [2];
  logic [CW-1:0] ic    [2];
  logic [DW-1:0] id    [2];
  logic          ov    [2];
  logic          orr   [2];
  logic [CW-1:0] oc    [2];
  logic [DW-1:0] od    [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // index 0: SKID=0, index 1: SKID=1
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ic[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_ctrl(oc[0]), .out_data(od[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ic[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_ctrl(oc[1]), .out_data(od[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] x, input logic r, input logic f);
    iv[d] = v; ic[d] = c; id[d] = x; orr[d] = r; flush[d] = f;
  endtask

  logic [CW+DW-1:0] sb [2][$];
  logic [CW+DW-1:0] exp_e;
  logic             pend [2];
  logic [DW-1:0]    seq  [2];

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), 128'(ov[d]), 128'(0));
      check($sformatf("rst_ctrl%0d",  d), 128'(oc[d]), 128'(0));
      check($sformatf("rst_data%0d",  d), 128'(od[d]), 128'(0));
      check($sformatf("rst_ready%0d", d), 128'(ir[d]), 128'(1));
    end

    // Stall with skid: A then B held, released in order
    drive(1, 1'b1, 6'h01, 107'hA, 1'b0, 1'b0);
    cyc();
    check("stall_a_valid", 128'(ov[1]), 128'(1));
    check("stall_a_data",  128'(od[1]), 128'hA);
    check("stall_a_ready", 128'(ir[1]), 128'(1));
    drive(1, 1'b1, 6'h02, 107'hB, 1'b0, 1'b0);
    cyc();
    check("stall_two_ready", 128'(ir[1]), 128'(0));
    check("stall_two_head",  128'(od[1]), 128'hA);
    drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    check("stall_b_data",  128'(od[1]), 128'hB);
    check("stall_b_ctrl",  128'(oc[1]), 128'h02);
    check("stall_b_ready", 128'(ir[1]), 128'(1));
    cyc();
    check("stall_empty_valid", 128'(ov[1]), 128'(0));
    check("stall_empty_ctrl",  128'(oc[1]), 128'(0));
    check("stall_empty_hold",  128'(od[1]), 128'hB);

    // Flush while TWO with in_valid high, then flush a real push in ONE
    drive(1, 1'b1, 6'h3F, 107'h1, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b1, 6'h3F, 107'h2, 1'b0, 1'b0);
    cyc();
    check("flush_pre_ready", 128'(ir[1]), 128'(0));
    drive(1, 1'b1, 6'h3F, 107'h3, 1'b0, 1'b1);
    cyc();
    check("flush_two_valid", 128'(ov[1]), 128'(0));
    check("flush_two_ctrl",  128'(oc[1]), 128'(0));
    check("flush_two_data",  128'(od[1]), 128'h1);
    check("flush_two_ready", 128'(ir[1]), 128'(1));
    drive(1, 1'b1, 6'h3F, 107'h5, 1'b0, 1'b0);
    cyc();
    check("flush_one_fill", 128'(od[1]), 128'h5);
    drive(1, 1'b1, 6'h3F, 107'h6, 1'b0, 1'b1);
    cyc();
    check("flush_one_valid", 128'(ov[1]), 128'(0));
    check("flush_one_data",  128'(od[1]), 128'h5);
    drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    check("flush_nothing", 128'(ov[1]), 128'(0));

    // Reset mid-stream from TWO
    drive(1, 1'b1, 6'h3F, 107'h1, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b1, 6'h3F, 107'h2, 1'b0, 1'b0);
    cyc();
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_valid", 128'(ov[1]), 128'(0));
    check("midrst_ctrl",  128'(oc[1]), 128'(0));
    check("midrst_data",  128'(od[1]), 128'(0));
    check("midrst_ready", 128'(ir[1]), 128'(1));
    orr[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("midrst_after", 128'(ov[1]), 128'(0));
    end

    // Bubble gating
    drive(1, 1'b1, 6'h21, 107'h7, 1'b1, 1'b0);
    cyc();
    check("bubble_ctrl", 128'(oc[1]), 128'h21);
    drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    check("bubble_gated", 128'(oc[1]), 128'(0));
    check("bubble_hold",  128'(od[1]), 128'h7);

    // Streaming one entry per cycle on both variants
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) drive(d, 1'b1, 6'h04, DW'(i), 1'b1, 1'b0);
      cyc();
      for (int d = 0; d < 2; d++) begin
        check($sformatf("stream%0d_valid_%0d", d, i), 128'(ov[d]), 128'(1));
        check($sformatf("stream%0d_data_%0d",  d, i), 128'(od[d]), 128'(i));
      end
    end
    for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    for (int d = 0; d < 2; d++) check($sformatf("stream%0d_drain", d), 128'(ov[d]), 128'(0));

    // Randomised handshake against a queue scoreboard
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0;
      seq[d]  = DW'(100);
    end
    for (int t = 0; t < 1000; t++) begin
      for (int d = 0; d < 2; d++) begin
        if (!pend[d]) begin
          iv[d] = 1'($urandom_range(0, 1));
          ic[d] = CW'($urandom_range(0, 63));
          id[d] = seq[d];
        end
        orr[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rnd%0d_valid", d), 128'(ov[d]), 128'(sb[d].size() != 0));
        if (sb[d].size() == 0) begin
          check($sformatf("rnd%0d_empty_ready", d), 128'(ir[d]), 128'(1));
          check($sformatf("rnd%0d_bubble", d), 128'(oc[d]), 128'(0));
        end
        if (ov[d] && orr[d] && sb[d].size() != 0) begin
          exp_e = sb[d].pop_front();
          check($sformatf("rnd%0d_head", d), 128'({oc[d], od[d]}), 128'(exp_e));
        end
        if (iv[d] && ir[d]) begin
          sb[d].push_back({ic[d], id[d]});
          seq[d] = seq[d] + DW'(1);
          pend[d] = 1'b0;
        end else begin
          pend[d] = iv[d];
        end
      end
      cyc();
    end
    for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && sb[d].size() != 0) begin
          exp_e = sb[d].pop_front();
          check($sformatf("drain%0d_head", d), 128'({oc[d], od[d]}), 128'(exp_e));
        end
      end
      cyc();
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("drain%0d_left", d), 128'(sb[d].size()), 128'(0));
      check($sformatf("drain%0d_valid", d), 128'(ov[d]), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
